// File: rtl/gpio_sw_debounce.sv
// rtl/gpio_sw_debounce.sv - synchronise and debounce raw switch pins
// Each channel emits a clean level, one-cycle rise/fall strobes and a press-toggled state.
module gpio_sw_debounce #(
  parameter int NUM_SW      = 2,
  parameter int DEB_CYCLES  = 100000,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk100,
  input  logic              rst,
  input  logic [NUM_SW-1:0] GPIO_SW,
  output logic [NUM_SW-1:0] sw_db,
  output logic [NUM_SW-1:0] sw_rise,
  output logic [NUM_SW-1:0] sw_fall,
  output logic [NUM_SW-1:0] sw_toggle
);

  localparam int CNT_W = $clog2(DEB_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEB_CYCLES - 1);

  if (DEB_CYCLES < 2) begin : g_bad_deb
    $error("DEB_CYCLES must be >= 2");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be >= 2");
  end

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    QUAL_HI = 2'd1,
    IDLE_HI = 2'd2,
    QUAL_LO = 2'd3
  } state_t;

  logic [NUM_SW-1:0] r_sync [SYNC_STAGES];
  state_t            r_state [NUM_SW];
  logic [CNT_W-1:0]  r_cnt [NUM_SW];
  logic [NUM_SW-1:0] r_db;
  logic [NUM_SW-1:0] r_rise;
  logic [NUM_SW-1:0] r_fall;
  logic [NUM_SW-1:0] r_toggle;
  logic [NUM_SW-1:0] w_s;

  assign w_s       = r_sync[SYNC_STAGES-1];
  assign sw_db     = r_db;
  assign sw_rise   = r_rise;
  assign sw_fall   = r_fall;
  assign sw_toggle = r_toggle;

  // Plain flop chain: nothing may sit between stages or metastability can leak through.
  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SYNC_STAGES; k++) r_sync[k] <= '0;
    end else begin
      r_sync[0] <= GPIO_SW;
      for (int k = 1; k < SYNC_STAGES; k++) r_sync[k] <= r_sync[k-1];
    end
  end

  always_ff @(posedge clk100 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_SW; i++) begin
        r_state[i] <= IDLE_LO;
        r_cnt[i]   <= '0;
      end
      r_db     <= '0;
      r_rise   <= '0;
      r_fall   <= '0;
      r_toggle <= '0;
    end else begin
      r_rise <= '0;
      r_fall <= '0;
      for (int i = 0; i < NUM_SW; i++) begin
        case (r_state[i])
          IDLE_LO: begin
            if (w_s[i]) begin
              r_cnt[i]   <= CNT_W'(1);
              r_state[i] <= QUAL_HI;
            end else begin
              r_cnt[i] <= '0;
            end
          end
          QUAL_HI: begin
            if (!w_s[i]) begin
              r_cnt[i]   <= '0;
              r_state[i] <= IDLE_LO;
            end else if (r_cnt[i] == CNT_MAX) begin
              r_cnt[i]    <= '0;
              r_state[i]  <= IDLE_HI;
              r_db[i]     <= 1'b1;
              r_rise[i]   <= 1'b1;
              r_toggle[i] <= ~r_toggle[i];
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          IDLE_HI: begin
            if (!w_s[i]) begin
              r_cnt[i]   <= CNT_W'(1);
              r_state[i] <= QUAL_LO;
            end else begin
              r_cnt[i] <= '0;
            end
          end
          QUAL_LO: begin
            if (w_s[i]) begin
              r_cnt[i]   <= '0;
              r_state[i] <= IDLE_HI;
            end else if (r_cnt[i] == CNT_MAX) begin
              r_cnt[i]   <= '0;
              r_state[i] <= IDLE_LO;
              r_db[i]    <= 1'b0;
              r_fall[i]  <= 1'b1;
            end else begin
              r_cnt[i] <= r_cnt[i] + CNT_W'(1);
            end
          end
          default: begin
            r_cnt[i]   <= '0;
            r_state[i] <= IDLE_LO;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_sw_debounce.sv
// tb/tb_gpio_sw_debounce.sv - directed checks of gpio_sw_debounce with DEB_CYCLES=8, SYNC_STAGES=2
module tb_gpio_sw_debounce;

  logic       clk100 = 1'b0;
  logic       rst    = 1'b1;
  logic [1:0] GPIO_SW = 2'b00;
  logic [1:0] sw_db, sw_rise, sw_fall, sw_toggle;

  int n_checks = 0;
  int n_fail   = 0;

  gpio_sw_debounce #(
    .NUM_SW(2),
    .DEB_CYCLES(8),
    .SYNC_STAGES(2)
  ) dut (
    .clk100   (clk100),
    .rst      (rst),
    .GPIO_SW  (GPIO_SW),
    .sw_db    (sw_db),
    .sw_rise  (sw_rise),
    .sw_fall  (sw_fall),
    .sw_toggle(sw_toggle)
  );

  always #5 clk100 = ~clk100;

  // A segment holds rst/GPIO_SW for n cycles; outputs must stay quiet at pre_* until
  // the last cycle, where end_* is required.
  typedef struct {
    logic       rst;
    logic [1:0] sw;
    int         n;
    logic [1:0] pre_db;
    logic [1:0] pre_tog;
    logic [1:0] end_db;
    logic [1:0] end_rise;
    logic [1:0] end_fall;
    logic [1:0] end_tog;
  } seg_t;

  seg_t tbl [13];

  task automatic check(input string name, input int cyc, input logic [1:0] e_db,
                       input logic [1:0] e_rise, input logic [1:0] e_fall,
                       input logic [1:0] e_tog);
    n_checks++;
    if (sw_db !== e_db || sw_rise !== e_rise || sw_fall !== e_fall || sw_toggle !== e_tog) begin
      n_fail++;
      $display("FAIL %s cyc %0d: got db=%b rise=%b fall=%b tog=%b, want db=%b rise=%b fall=%b tog=%b",
               name, cyc, sw_db, sw_rise, sw_fall, sw_toggle, e_db, e_rise, e_fall, e_tog);
    end
  endtask

  // Inputs change and outputs are sampled on the falling edge.
  task automatic run_seg(input seg_t s, input string name);
    rst     = s.rst;
    GPIO_SW = s.sw;
    for (int c = 1; c <= s.n; c++) begin
      @(posedge clk100);
      @(negedge clk100);
      if (c == s.n)
        check(name, c, s.end_db, s.end_rise, s.end_fall, s.end_tog);
      else
        check(name, c, s.pre_db, 2'b00, 2'b00, s.pre_tog);
    end
  endtask

  function automatic seg_t quiet(input logic r, input logic [1:0] sw, input int n,
                                 input logic [1:0] db, input logic [1:0] tog);
    seg_t s;
    s = '{r, sw, n, db, tog, db, 2'b00, 2'b00, tog};
    return s;
  endfunction

  initial begin
    // rst, sw, n, pre_db, pre_tog, end_db, end_rise, end_fall, end_tog
    tbl[0]  = '{1'b1, 2'b11,  5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[1]  = '{1'b0, 2'b11, 10, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00, 2'b11};
    tbl[2]  = '{1'b0, 2'b11,  1, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b11};
    tbl[3]  = '{1'b1, 2'b00,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[4]  = '{1'b0, 2'b00,  3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    tbl[5]  = '{1'b0, 2'b01, 10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
    tbl[6]  = '{1'b0, 2'b01,  3, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01};
    tbl[7]  = '{1'b0, 2'b00, 10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01};
    tbl[8]  = '{1'b0, 2'b00,  2, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01};
    tbl[9]  = '{1'b0, 2'b01, 10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b00, 2'b00};
    tbl[10] = '{1'b0, 2'b01,  2, 2'b01, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00};
    tbl[11] = '{1'b0, 2'b00, 10, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    tbl[12] = '{1'b0, 2'b00,  2, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    for (int t = 0; t < 13; t++) run_seg(tbl[t], $sformatf("tbl%0d", t));

    // Bounce on ch0: 3 high / 3 low for 30 cycles, nothing may come out.
    for (int p = 0; p < 5; p++) begin
      run_seg(quiet(1'b0, 2'b01, 3, 2'b00, 2'b00), "bounce_hi");
      run_seg(quiet(1'b0, 2'b00, 3, 2'b00, 2'b00), "bounce_lo");
    end
    run_seg('{1'b0, 2'b01, 10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01}, "bounce_settle");
    run_seg(quiet(1'b0, 2'b01, 1, 2'b01, 2'b01), "bounce_single");
    run_seg('{1'b0, 2'b00, 10, 2'b01, 2'b01, 2'b00, 2'b00, 2'b01, 2'b01}, "bounce_release");
    run_seg(quiet(1'b0, 2'b00, 1, 2'b00, 2'b01), "bounce_idle");

    // Glitch on ch1: 7 cycles is rejected, 8 cycles is accepted.
    run_seg(quiet(1'b0, 2'b10, 7, 2'b00, 2'b01), "glitch7_hi");
    run_seg(quiet(1'b0, 2'b00, 15, 2'b00, 2'b01), "glitch7_lo");
    run_seg(quiet(1'b0, 2'b10, 8, 2'b00, 2'b01), "pulse8_hi");
    run_seg('{1'b0, 2'b00, 2, 2'b00, 2'b01, 2'b10, 2'b10, 2'b00, 2'b11}, "pulse8_rise");
    run_seg('{1'b0, 2'b00, 8, 2'b10, 2'b11, 2'b00, 2'b00, 2'b10, 2'b11}, "pulse8_fall");
    run_seg(quiet(1'b0, 2'b00, 2, 2'b00, 2'b11), "pulse8_idle");

    // Reset while ch0 counter sits at 5, then requalify from zero.
    run_seg(quiet(1'b0, 2'b01, 7, 2'b00, 2'b11), "rstmid_qual");
    run_seg(quiet(1'b1, 2'b01, 2, 2'b00, 2'b00), "rstmid_hold");
    run_seg('{1'b0, 2'b01, 10, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00, 2'b01}, "rstmid_rise");
    run_seg(quiet(1'b0, 2'b01, 2, 2'b01, 2'b01), "rstmid_after");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
